hazard_stall_ctrl: RTL and testbench

Parametrised hazard and stall controller for the pipelined RISC-V core. It sits between the ID stage and the pipeline registers. It detects load-use hazards, with a configurable bubble count and x0 / unused-source qualification, and stalls the front of the pipe for multi-cycle multiply/divide operations in EX. It also gates branch flushes against stalls and keeps saturating stall and flush counters for performance analysis.

---
 rtl/hazard_stall_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / mul-div hazard and stall controller
// Combinational pipeline controls from a 4-state FSM plus saturating stall/flush counters.
module hazard_stall_ctrl #(
    parameter int ADDR_W   = 5,
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 4,
    parameter int CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ID_EX_MemRead_i,
    input  logic [ADDR_W-1:0] ID_EX_RDaddr_i,
    input  logic              ID_EX_MDU_i,
    input  logic [ADDR_W-1:0] RS1addr_i,
    input  logic [ADDR_W-1:0] RS2addr_i,
    input  logic              RS1use_i,
    input  logic              RS2use_i,
    input  logic              Branch_i,
    output logic              NoOp_o,
    output logic              Stall_o,
    output logic              PCWrite_o,
    output logic              EXHold_o,
    output logic              Flush_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam logic [1:0] ST_RUN       = 2'd0;
    localparam logic [1:0] ST_LOAD_WAIT = 2'd1;
    localparam logic [1:0] ST_MDU_WAIT  = 2'd2;
    localparam logic [1:0] ST_MDU_DONE  = 2'd3;

    localparam bit         MDU_EN   = (MDU_LAT > 1);
    localparam bit         LOAD_MC  = (LOAD_LAT > 1);
    localparam bit         MDU_SHORT = (MDU_LAT == 2);
    localparam logic [3:0] LOAD_CNT = 4'(LOAD_LAT - 1);
    localparam logic [3:0] MDU_CNT  = 4'(MDU_LAT - 2);

    logic [1:0]       r_state;
    logic [3:0]       r_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic [1:0] w_state_nxt;
    logic [3:0] w_cnt_nxt;
    logic       w_hazard;
    logic       w_mdu_go;
    logic       w_noop;
    logic       w_stall;
    logic       w_pcwrite;
    logic       w_exhold;
    logic       w_flush;

    assign w_hazard = ID_EX_MemRead_i && (ID_EX_RDaddr_i != '0) &&
                      ((RS1use_i && (RS1addr_i == ID_EX_RDaddr_i)) ||
                       (RS2use_i && (RS2addr_i == ID_EX_RDaddr_i)));

    // MDU_DONE deliberately excluded: the finished mul/div is still in EX there
    assign w_mdu_go = MDU_EN && ID_EX_MDU_i && (r_state == ST_RUN);

    always_comb begin
        w_noop      = 1'b0;
        w_stall     = 1'b0;
        w_pcwrite   = 1'b1;
        w_exhold    = 1'b0;
        w_flush     = 1'b0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_LOAD_WAIT: begin
                w_noop    = 1'b1;
                w_stall   = 1'b1;
                w_pcwrite = 1'b0;
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_MDU_WAIT: begin
                w_exhold  = 1'b1;
                w_stall   = 1'b1;
                w_pcwrite = 1'b0;
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt = ST_MDU_DONE;
                end
            end
            default: begin
                if (w_mdu_go) begin
                    w_exhold  = 1'b1;
                    w_stall   = 1'b1;
                    w_pcwrite = 1'b0;
                    if (MDU_SHORT) begin
                        w_state_nxt = ST_MDU_DONE;
                    end else begin
                        w_state_nxt = ST_MDU_WAIT;
                        w_cnt_nxt   = MDU_CNT;
                    end
                end else if (w_hazard) begin
                    w_noop    = 1'b1;
                    w_stall   = 1'b1;
                    w_pcwrite = 1'b0;
                    if (LOAD_MC) begin
                        w_state_nxt = ST_LOAD_WAIT;
                        w_cnt_nxt   = LOAD_CNT;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else begin
                    w_flush     = Branch_i;
                    w_state_nxt = ST_RUN;
                end
            end
        endcase
    end

    // Reset masks the outputs combinationally so an aborted stall vanishes before the next edge
    assign NoOp_o    = w_noop    && !rst_i;
    assign Stall_o   = w_stall   && !rst_i;
    assign PCWrite_o = w_pcwrite || rst_i;
    assign EXHold_o  = w_exhold  && !rst_i;
    assign Flush_o   = w_flush   && !rst_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_RUN;
            r_cnt       <= 4'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (!PCWrite_o && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (Flush_o && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - self-checking bench for hazard_stall_ctrl
// Three parameterisations driven in parallel against a remaining-cycles reference model.
module tb_hazard_stall_ctrl;

    typedef struct packed {
        logic       rst;
        logic       mr;
        logic [4:0] rd;
        logic       mdu;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       u1;
        logic       u2;
        logic       br;
    } in_t;

    typedef struct {
        string      name;
        in_t        i;
        logic [4:0] exp;
    } vec_t;

    // output vector order: {NoOp, Stall, PCWrite, EXHold, Flush}
    localparam logic [4:0] O_IDLE  = 5'b00100;
    localparam logic [4:0] O_FLUSH = 5'b00101;
    localparam logic [4:0] O_LOAD  = 5'b11000;
    localparam logic [4:0] O_MDU   = 5'b01010;

    int ll [3] = '{1, 3, 2};
    int ml [3] = '{4, 1, 2};
    int cw [3] = '{16, 4, 16};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i, mr_i, mdu_i, u1_i, u2_i, br_i;
    logic [4:0] rd_i, r1_i, r2_i;

    logic        noop_a, stall_a, pcw_a, exh_a, fl_a;
    logic        noop_b, stall_b, pcw_b, exh_b, fl_b;
    logic        noop_c, stall_c, pcw_c, exh_c, fl_c;
    logic [15:0] sc_a, fc_a, sc_c, fc_c;
    logic [3:0]  sc_b, fc_b;

    hazard_stall_ctrl #(.ADDR_W(5), .LOAD_LAT(1), .MDU_LAT(4), .CNT_W(16)) u_a (
        .clk_i(clk), .rst_i(rst_i), .ID_EX_MemRead_i(mr_i), .ID_EX_RDaddr_i(rd_i),
        .ID_EX_MDU_i(mdu_i), .RS1addr_i(r1_i), .RS2addr_i(r2_i), .RS1use_i(u1_i),
        .RS2use_i(u2_i), .Branch_i(br_i), .NoOp_o(noop_a), .Stall_o(stall_a),
        .PCWrite_o(pcw_a), .EXHold_o(exh_a), .Flush_o(fl_a),
        .stall_cnt_o(sc_a), .flush_cnt_o(fc_a));

    hazard_stall_ctrl #(.ADDR_W(5), .LOAD_LAT(3), .MDU_LAT(1), .CNT_W(4)) u_b (
        .clk_i(clk), .rst_i(rst_i), .ID_EX_MemRead_i(mr_i), .ID_EX_RDaddr_i(rd_i),
        .ID_EX_MDU_i(mdu_i), .RS1addr_i(r1_i), .RS2addr_i(r2_i), .RS1use_i(u1_i),
        .RS2use_i(u2_i), .Branch_i(br_i), .NoOp_o(noop_b), .Stall_o(stall_b),
        .PCWrite_o(pcw_b), .EXHold_o(exh_b), .Flush_o(fl_b),
        .stall_cnt_o(sc_b), .flush_cnt_o(fc_b));

    hazard_stall_ctrl #(.ADDR_W(5), .LOAD_LAT(2), .MDU_LAT(2), .CNT_W(16)) u_c (
        .clk_i(clk), .rst_i(rst_i), .ID_EX_MemRead_i(mr_i), .ID_EX_RDaddr_i(rd_i),
        .ID_EX_MDU_i(mdu_i), .RS1addr_i(r1_i), .RS2addr_i(r2_i), .RS1use_i(u1_i),
        .RS2use_i(u2_i), .Branch_i(br_i), .NoOp_o(noop_c), .Stall_o(stall_c),
        .PCWrite_o(pcw_c), .EXHold_o(exh_c), .Flush_o(fl_c),
        .stall_cnt_o(sc_c), .flush_cnt_o(fc_c));

    int checks   = 0;
    int failures = 0;

    // model: bubbles still owed, EX-hold cycles still owed, and "mul/div just finished"
    int m_load [3];
    int m_mdu  [3];
    bit m_post [3];
    int m_sc   [3];
    int m_fc   [3];

    in_t        vin;
    logic [4:0] last_out [3];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [4:0] dut_out(input int k);
        case (k)
            0:       return {noop_a, stall_a, pcw_a, exh_a, fl_a};
            1:       return {noop_b, stall_b, pcw_b, exh_b, fl_b};
            default: return {noop_c, stall_c, pcw_c, exh_c, fl_c};
        endcase
    endfunction

    function automatic int dut_sc(input int k);
        case (k)
            0:       return int'(sc_a);
            1:       return int'(sc_b);
            default: return int'(sc_c);
        endcase
    endfunction

    function automatic int dut_fc(input int k);
        case (k)
            0:       return int'(fc_a);
            1:       return int'(fc_b);
            default: return int'(fc_c);
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_load[k] = 0;
            m_mdu[k]  = 0;
            m_post[k] = 1'b0;
            m_sc[k]   = 0;
            m_fc[k]   = 0;
        end
    endtask

    task automatic model_step(input int k, output logic [4:0] o);
        bit hz;
        int mx;
        hz = vin.mr && (vin.rd != 0) &&
             ((vin.u1 && vin.r1 == vin.rd) || (vin.u2 && vin.r2 == vin.rd));
        mx = (1 << cw[k]) - 1;
        o  = O_IDLE;
        if (vin.rst) return;
        if (m_load[k] > 0) begin
            o = O_LOAD;
            m_load[k]--;
        end else if (m_mdu[k] > 0) begin
            o = O_MDU;
            m_mdu[k]--;
            if (m_mdu[k] == 0) m_post[k] = 1'b1;
        end else if (!m_post[k] && vin.mdu && ml[k] > 1) begin
            o = O_MDU;
            m_mdu[k]  = ml[k] - 2;
            m_post[k] = (ml[k] == 2);
        end else begin
            m_post[k] = 1'b0;
            if (hz) begin
                o = O_LOAD;
                m_load[k] = ll[k] - 1;
            end else begin
                o = vin.br ? O_FLUSH : O_IDLE;
            end
        end
        if (!o[2]) m_sc[k] = (m_sc[k] + 1 > mx) ? mx : m_sc[k] + 1;
        if (o[0])  m_fc[k] = (m_fc[k] + 1 > mx) ? mx : m_fc[k] + 1;
    endtask

    task automatic cycle();
        logic [4:0] e;
        @(negedge clk);
        rst_i = vin.rst; mr_i = vin.mr; rd_i = vin.rd; mdu_i = vin.mdu;
        r1_i  = vin.r1;  r2_i = vin.r2; u1_i = vin.u1; u2_i = vin.u2; br_i = vin.br;
        #1;
        if (vin.rst) model_reset();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("dut%0d_stall_cnt", k), dut_sc(k), m_sc[k]);
            check($sformatf("dut%0d_flush_cnt", k), dut_fc(k), m_fc[k]);
            model_step(k, e);
            last_out[k] = dut_out(k);
            check($sformatf("dut%0d_outputs", k), int'(last_out[k]), int'(e));
        end
    endtask

    function automatic in_t idle_in();
        in_t t;
        t = '0;
        t.rd = 5'd5; t.r1 = 5'd1; t.r2 = 5'd2;
        return t;
    endfunction

    function automatic in_t haz_in();
        in_t t;
        t = idle_in();
        t.mr = 1'b1; t.r1 = 5'd5; t.u1 = 1'b1;
        return t;
    endfunction

    vec_t vecs [10];

    initial begin
        in_t t;
        model_reset();
        vin = idle_in();
        vin.rst = 1'b1;
        rst_i = 1'b1; mr_i = 0; rd_i = 0; mdu_i = 0; r1_i = 0; r2_i = 0;
        u1_i = 0; u2_i = 0; br_i = 0;

        // table applies to dut0 (LOAD_LAT=1 keeps it in RUN between rows)
        t = idle_in(); t.rst = 1'b1; t.mr = 1'b1; t.r1 = 5'd5; t.u1 = 1'b1; t.br = 1'b1;
        vecs[0] = '{"reset_forces_idle", t, O_IDLE};
        t = haz_in();
        vecs[1] = '{"hazard_rs1", t, O_LOAD};
        t = idle_in();
        vecs[2] = '{"idle", t, O_IDLE};
        t = haz_in(); t.rd = 5'd0; t.r1 = 5'd0;
        vecs[3] = '{"rd_x0", t, O_IDLE};
        t = haz_in(); t.u1 = 1'b0;
        vecs[4] = '{"rs1_unused", t, O_IDLE};
        t = idle_in(); t.mr = 1'b1; t.r2 = 5'd5; t.u2 = 1'b1;
        vecs[5] = '{"hazard_rs2", t, O_LOAD};
        t = idle_in(); t.mr = 1'b1; t.r2 = 5'd5; t.u2 = 1'b0;
        vecs[6] = '{"rs2_unused", t, O_IDLE};
        t = idle_in(); t.br = 1'b1;
        vecs[7] = '{"branch_flush", t, O_FLUSH};
        t = haz_in(); t.br = 1'b1;
        vecs[8] = '{"branch_with_hazard", t, O_LOAD};
        t = haz_in(); t.mr = 1'b0; t.br = 1'b1;
        vecs[9] = '{"no_load_branch", t, O_FLUSH};

        for (int v = 0; v < 10; v++) begin
            vin = vecs[v].i;
            cycle();
            check({"tbl_", vecs[v].name}, int'(last_out[0]), int'(vecs[v].exp));
        end
        vin = idle_in();
        cycle();
        check("tbl_stall_cnt_total", int'(sc_a), 3);
        check("tbl_flush_cnt_total", int'(fc_a), 2);

        // load-use with LOAD_LAT=3 (dut1): three bubbles, branch in cycle 2 dropped
        vin = idle_in(); vin.rst = 1'b1; cycle();
        vin = haz_in(); cycle();
        check("ll3_cyc1", int'(last_out[1]), int'(O_LOAD));
        vin = idle_in(); vin.br = 1'b1; cycle();
        check("ll3_cyc2_no_flush", int'(last_out[1]), int'(O_LOAD));
        vin = idle_in(); cycle();
        check("ll3_cyc3", int'(last_out[1]), int'(O_LOAD));
        cycle();
        check("ll3_released", int'(last_out[1]), int'(O_IDLE));
        check("ll3_stall_cnt", int'(sc_b), 3);
        check("ll3_flush_cnt", int'(fc_b), 0);

        // MDU held 4 cycles: dut0 holds 3 then releases, dut1 never holds, dut2 holds 1
        vin = idle_in(); vin.mdu = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            check($sformatf("mdu4_cyc%0d", c + 1), int'(last_out[0]), int'(c < 3 ? O_MDU : O_IDLE));
            check($sformatf("mdu1_cyc%0d", c + 1), int'(last_out[1]), int'(O_IDLE));
        end
        cycle();
        check("mdu4_back_to_back", int'(last_out[0]), int'(O_MDU));

        // reset asserted asynchronously in MDU_WAIT cycle 2
        vin = idle_in(); vin.rst = 1'b1; cycle();
        vin = idle_in(); vin.mdu = 1'b1;
        cycle();
        cycle();
        @(negedge clk);
        #1;
        check("mdu_wait2_hold", int'(dut_out(0)), int'(O_MDU));
        #2 rst_i = 1'b1;
        #1;
        check("async_rst_outputs", int'(dut_out(0)), int'(O_IDLE));
        check("async_rst_stall_cnt", int'(sc_a), 0);
        check("async_rst_flush_cnt", int'(fc_a), 0);
        model_reset();
        vin.rst = 1'b1; cycle();
        vin = idle_in(); cycle();
        check("after_rst_run", int'(last_out[0]), int'(O_IDLE));

        // saturation of the 4-bit counter on dut1
        vin = idle_in(); vin.rst = 1'b1; cycle();
        vin = haz_in();
        for (int c = 0; c < 20; c++) cycle();
        vin = idle_in(); cycle();
        check("sat_stall_cnt_w4", int'(sc_b), 15);
        check("sat_stall_cnt_w16", int'(sc_a), 20);

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            vin.rst = ($urandom_range(0, 79) == 0);
            vin.mr  = $urandom_range(0, 1);
            vin.rd  = 5'($urandom_range(0, 3));
            vin.mdu = ($urandom_range(0, 3) == 0);
            vin.r1  = 5'($urandom_range(0, 3));
            vin.r2  = 5'($urandom_range(0, 3));
            vin.u1  = $urandom_range(0, 1);
            vin.u2  = $urandom_range(0, 1);
            vin.br  = $urandom_range(0, 1);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
